// File: rtl/uart_rx_regbank.sv
// 8N1 UART receiver (16x oversampled, majority vote) feeding a packet parser that
// writes a flat register bank; supports single and burst writes with error recovery.
module uart_rx_regbank #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int NUM_REGS     = 8,
  parameter int STATUS_ADDR  = 7,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic [7:0]            i_status_in,
  output logic [NUM_REGS*8-1:0] o_regs_flat,
  output logic                  o_wr_stb,
  output logic [6:0]            o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_frame_err,
  output logic                  o_timeout,
  output logic [7:0]            o_err_count
);

  localparam int DIV       = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_LIMIT = TIMEOUT_BITS * 16;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
  localparam logic [7:0] NUM_REGS_L    = 8'(NUM_REGS);
  localparam logic [6:0] STATUS_ADDR_L = 7'(STATUS_ADDR);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_ADDR, P_DATA, P_COUNT, P_BURST} p_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  rx_state_t        r_rx_state, w_rx_next;
  p_state_t         r_p_state, w_p_next;
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_phase;
  logic [2:0]       r_bit_cnt;
  logic             r_armed;
  logic             r_s7, r_s8;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_byte_valid;
  logic             r_frame_err;
  logic [6:0]       r_addr;
  logic [7:0]       r_remaining;
  logic [GAP_W-1:0] r_gap;
  logic             r_timeout;
  logic [7:0]       r_err_count;
  logic             r_wr_stb;
  logic [6:0]       r_wr_addr;
  logic [7:0]       r_wr_data;
  logic [7:0]       r_regs [NUM_REGS];

  logic w_fall, w_tick, w_start;
  logic w_shift_en, w_byte_ok, w_stop_bad;
  logic w_do_write, w_write_hit, w_gap_hit;

  assign w_fall  = r_rx_prev & ~r_rx_sync;
  assign w_tick  = (r_div == DIV_W'(DIV - 1));
  assign w_start = (r_rx_state == RX_IDLE) && w_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Divider restarts on a start edge so sample points are centred on the frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (w_start || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next  = r_rx_state;
    w_shift_en = 1'b0;
    w_byte_ok  = 1'b0;
    w_stop_bad = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_fall) w_rx_next = RX_START;
        else        w_rx_next = RX_IDLE;
      end
      RX_START: begin
        if (w_tick && r_phase == 4'd8) begin
          if (r_rx_sync) w_rx_next = RX_IDLE;
          else           w_rx_next = RX_DATA;
        end else begin
          w_rx_next = RX_START;
        end
      end
      RX_DATA: begin
        // r_armed masks the tail of the start bit until the first data bit begins.
        if (w_tick && r_phase == 4'd9 && r_armed) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_rx_next = RX_STOP;
          else                   w_rx_next = RX_DATA;
        end else begin
          w_rx_next = RX_DATA;
        end
      end
      RX_STOP: begin
        if (w_tick && r_phase == 4'd8) begin
          w_rx_next = RX_IDLE;
          if (r_rx_sync) w_byte_ok  = 1'b1;
          else           w_stop_bad = 1'b1;
        end else begin
          w_rx_next = RX_STOP;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase      <= 4'd0;
      r_bit_cnt    <= 3'd0;
      r_armed      <= 1'b0;
      r_s7         <= 1'b1;
      r_s8         <= 1'b1;
      r_shift      <= 8'd0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_byte_ok;
      r_frame_err  <= w_stop_bad;
      if (w_byte_ok) r_byte <= r_shift;
      if (w_start) begin
        r_phase   <= 4'd0;
        r_bit_cnt <= 3'd0;
        r_armed   <= 1'b0;
      end else if (w_tick) begin
        r_phase <= r_phase + 4'd1;
        if (r_phase == 4'd15) r_armed <= 1'b1;
        if (r_phase == 4'd7)  r_s7 <= r_rx_sync;
        if (r_phase == 4'd8)  r_s8 <= r_rx_sync;
      end
      if (w_shift_en) begin
        r_shift   <= {majority3(r_s7, r_s8, r_rx_sync), r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  assign w_gap_hit = (r_p_state != P_ADDR) && !r_byte_valid && (r_rx_state == RX_IDLE)
                     && w_tick && (r_gap == GAP_W'(GAP_LIMIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p_state <= P_ADDR;
    end else begin
      r_p_state <= w_p_next;
    end
  end

  always_comb begin
    w_p_next   = r_p_state;
    w_do_write = 1'b0;
    if (r_frame_err || w_gap_hit) begin
      w_p_next = P_ADDR;
    end else if (r_byte_valid) begin
      case (r_p_state)
        P_ADDR: begin
          if (r_byte[7]) w_p_next = P_COUNT;
          else           w_p_next = P_DATA;
        end
        P_DATA: begin
          w_do_write = 1'b1;
          w_p_next   = P_ADDR;
        end
        P_COUNT: begin
          if (r_byte == 8'd0) w_p_next = P_ADDR;
          else                w_p_next = P_BURST;
        end
        P_BURST: begin
          w_do_write = 1'b1;
          if (r_remaining == 8'd1) w_p_next = P_ADDR;
          else                     w_p_next = P_BURST;
        end
        default: w_p_next = P_ADDR;
      endcase
    end else begin
      w_p_next = r_p_state;
    end
  end

  assign w_write_hit = w_do_write && ({1'b0, r_addr} < NUM_REGS_L) && (r_addr != STATUS_ADDR_L);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= 7'd0;
      r_remaining <= 8'd0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= 7'd0;
      r_wr_data   <= 8'd0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= 8'd0;
    end else begin
      r_wr_stb <= w_write_hit;
      if (w_write_hit) begin
        r_wr_addr <= r_addr;
        r_wr_data <= r_byte;
      end
      if (r_byte_valid && r_p_state == P_ADDR) begin
        r_addr <= r_byte[6:0];
      end else if (w_do_write && r_p_state == P_BURST) begin
        r_addr <= r_addr + 7'd1;
      end
      if (r_byte_valid && r_p_state == P_COUNT) begin
        r_remaining <= r_byte;
      end else if (w_do_write && r_p_state == P_BURST) begin
        r_remaining <= r_remaining - 8'd1;
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        if (k == STATUS_ADDR) r_regs[k] <= i_status_in;
        else if (w_write_hit && r_addr == 7'(k)) r_regs[k] <= r_byte;
        else r_regs[k] <= r_regs[k];
      end
    end
  end

  // Gap counter only runs between bytes of an open packet; err_count merges coincident events.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gap       <= '0;
      r_timeout   <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_timeout <= w_gap_hit;
      if (r_p_state == P_ADDR || r_byte_valid || w_gap_hit) begin
        r_gap <= '0;
      end else if (r_rx_state == RX_IDLE && w_tick) begin
        r_gap <= r_gap + GAP_W'(1);
      end
      if ((r_frame_err || r_timeout) && r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs_flat[8*g +: 8] = r_regs[g];
  end

  assign o_wr_stb    = r_wr_stb;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_frame_err = r_frame_err;
  assign o_timeout   = r_timeout;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_uart_rx_regbank.sv
// Scoreboard bench for uart_rx_regbank: a packet-level model predicts register writes,
// a monitor pops them as wr_stb appears and compares.
`timescale 1ns/1ps
module tb_uart_rx_regbank;
  localparam int CLK_FREQ     = 32_000_000;
  localparam int BAUD_RATE    = 1_000_000;
  localparam int NUM_REGS     = 8;
  localparam int STATUS_ADDR  = 7;
  localparam int TIMEOUT_BITS = 20;
  localparam int DIV          = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int BIT          = 16 * DIV;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  rx  = 1'b1;
  logic [7:0]            status_in = 8'h00;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  wr_stb, frame_err, timeout;
  logic [6:0]            wr_addr;
  logic [7:0]            wr_data, err_count;

  uart_rx_regbank #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .NUM_REGS(NUM_REGS),
    .STATUS_ADDR(STATUS_ADDR), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_status_in(status_in),
    .o_regs_flat(regs_flat), .o_wr_stb(wr_stb), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_frame_err(frame_err), .o_timeout(timeout), .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [6:0] a; logic [7:0] d;} wr_t;
  wr_t        exp_q[$];
  logic [7:0] model[NUM_REGS];
  int checks = 0;
  int errors = 0;
  int fe_seen = 0;
  int to_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    wr_t e;
    if (frame_err) fe_seen++;
    if (timeout)   to_seen++;
    if (wr_stb) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr_stb: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    wr_t w;
    if (int'(a) < NUM_REGS && int'(a) != STATUS_ADDR) begin
      model[int'(a)] = d;
      w.a = a;
      w.d = d;
      exp_q.push_back(w);
    end
  endtask

  // Packet semantics: [addr][data] or [0x80|addr][n][d0..dn-1] with 7-bit wrapping addresses.
  task automatic model_packet(input logic [7:0] pkt[$]);
    logic [6:0] a;
    a = pkt[0][6:0];
    if (!pkt[0][7]) begin
      model_write(a, pkt[1]);
    end else begin
      for (int i = 0; i < int'(pkt[1]); i++) model_write(7'(int'(a) + i), pkt[2+i]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_packet(input logic [7:0] pkt[$], input int gap_bits);
    model_packet(pkt);
    foreach (pkt[i]) send_byte(pkt[i], 1'b1);
    repeat (gap_bits * BIT + 4) @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] exp;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NUM_REGS; k++) begin
      exp = (k == STATUS_ADDR) ? status_in : model[k];
      chk($sformatf("%s_reg%0d", tag, k), 32'(regs_flat[8*k +: 8]), 32'(exp));
    end
    chk($sformatf("%s_pending_writes", tag), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] pkt[$];
    int fe0, to0, n;
    for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
    status_in = 8'h5A;
    repeat (3) @(negedge clk);
    chk("reset_regs", 32'(regs_flat == '0), 32'd1);
    chk("reset_wr_stb", 32'(wr_stb), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("reset_pulses", 32'({frame_err, timeout}), 32'd0);
    rst = 1'b0;
    check_regs("status_after_reset");

    pkt = {8'h00, 8'h1D};
    send_packet(pkt, 1);
    check_regs("single");

    pkt = {8'h82, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_packet(pkt, 1);
    check_regs("burst");
    pkt = {8'h05, 8'h40};
    send_packet(pkt, 1);
    check_regs("single_after_burst");

    status_in = 8'h03;
    pkt = {8'h07, 8'hFF};
    send_packet(pkt, 1);
    check_regs("status_readonly");

    pkt = {8'h86, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    send_packet(pkt, 1);
    check_regs("burst_out_of_range");
    pkt = {8'hFF, 8'h03, 8'hA1, 8'hA2, 8'hA3};
    send_packet(pkt, 1);
    check_regs("burst_wrap");
    pkt = {8'h85, 8'h00};
    send_packet(pkt, 0);
    pkt = {8'h02, 8'h33};
    send_packet(pkt, 1);
    check_regs("burst_zero_count");

    fe0 = fe_seen;
    send_byte(8'h03, 1'b0);
    repeat (BIT) @(negedge clk);
    pkt = {8'h01, 8'h55};
    send_packet(pkt, 1);
    chk("frame_err_pulses", 32'(fe_seen - fe0), 32'd1);
    chk("frame_err_count", 32'(err_count), 32'd1);
    check_regs("after_frame_err");

    to0 = to_seen;
    send_byte(8'h06, 1'b1);
    repeat (25 * BIT) @(negedge clk);
    pkt = {8'h00, 8'h77};
    send_packet(pkt, 1);
    chk("timeout_pulses", 32'(to_seen - to0), 32'd1);
    chk("timeout_count", 32'(err_count), 32'd2);
    check_regs("after_timeout");

    for (int p = 0; p < 20; p++) begin
      pkt.delete();
      if (p % 5 == 0) status_in = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        pkt.push_back({1'b0, 7'($urandom_range(0, (p % 7 == 3) ? 127 : 9))});
        pkt.push_back(8'($urandom));
      end else begin
        n = $urandom_range(0, 4);
        pkt.push_back({1'b1, 7'($urandom_range(0, (p % 7 == 3) ? 127 : 9))});
        pkt.push_back(8'(n));
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      end
      send_packet(pkt, $urandom_range(0, 2));
      check_regs($sformatf("random%0d", p));
    end

    // Low pulse of three oversample ticks: must be taken as a false start.
    fe0 = fe_seen;
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_no_frame_err", 32'(fe_seen - fe0), 32'd0);
    check_regs("after_glitch");
    chk("total_timeouts", 32'(to_seen), 32'd1);
    chk("total_frame_errs", 32'(fe_seen), 32'd1);

    status_in = 8'h00;
    send_byte(8'h03, 1'b1);
    rx = 1'b0;
    repeat (4 * BIT) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
    repeat (2 * BIT) @(negedge clk);
    chk("reset_mid_err_count", 32'(err_count), 32'd0);
    pkt = {8'h01, 8'h12};
    send_packet(pkt, 1);
    check_regs("after_mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
